// File: rtl/mem_arbiter_pkg.sv
// Shared types and encodings for the two-port memory arbiter.
// Holds the FSM states, bus-owner tags, debug grant codes and the tie-break rule.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    // On a tie the port that did not win most recently gets the bus
    function automatic owner_t pickWinner(input logic iReq, input logic dReq, input logic lastData);
        if (iReq && dReq) begin
            return lastData ? OWN_I : OWN_D;
        end else if (dReq) begin
            return OWN_D;
        end
        return OWN_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port and external memory port around the arbiter.
// The slave view belongs to the arbiter; the master view to the CPU/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_wrt;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_wrt;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    logic              bus_err;
    logic [1:0]        grant;

    modport slave (
        input  i_req, i_addr, d_req, d_wrt, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_wdata, mem_read, mem_wrt,
               bus_err, grant
    );

    modport master (
        output i_req, i_addr, d_req, d_wrt, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_ack, d_rdata, d_ack, mem_addr, mem_wdata, mem_read, mem_wrt,
               bus_err, grant
    );

endinterface

// File: rtl/mem_arbiter_bus_timer.sv
// Wait-state counter for one memory access; o_tc flags that TIMEOUT
// stalled cycles have already elapsed, so the current cycle is the last one allowed.
module mem_arbiter_bus_timer #(
    parameter int TO_W    = 4,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    logic [TO_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + TO_W'(1);
        end
    end

    assign o_tc = (r_count == TO_W'(TIMEOUT));

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one memory port between instruction fetch and
// data accesses, with a bounded wait for mem_ready and fully registered outputs.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15,
    parameter int TO_W    = 4
) (
    input logic           clk,
    input logic           rst_n,
    mem_arbiter_if.slave  bus
);

    arb_state_t        r_state;
    owner_t            r_owner;
    logic              r_lastData;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic              r_memRead;
    logic              r_memWrt;
    logic [DATA_W-1:0] r_iRdata;
    logic [DATA_W-1:0] r_dRdata;
    logic              r_iAck;
    logic              r_dAck;
    logic              r_busErr;
    logic [1:0]        r_grant;

    logic              w_anyReq;
    owner_t            w_winner;
    logic              w_isStore;
    logic              w_tc;
    logic [DATA_W-1:0] w_capData;

    assign w_anyReq  = bus.i_req || bus.d_req;
    assign w_winner  = pickWinner(bus.i_req, bus.d_req, r_lastData);
    assign w_isStore = (w_winner == OWN_D) && bus.d_wrt;
    // An aborted access returns zero instead of whatever the bus happens to show
    assign w_capData = bus.mem_ready ? bus.mem_rdata : '0;

    mem_arbiter_bus_timer #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (r_state == ARB_IDLE),
        .i_en  ((r_state == ARB_BUSY) && !bus.mem_ready),
        .o_tc  (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ARB_IDLE;
            r_owner    <= OWN_I;
            r_lastData <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_memRead  <= 1'b0;
            r_memWrt   <= 1'b0;
            r_iRdata   <= '0;
            r_dRdata   <= '0;
            r_iAck     <= 1'b0;
            r_dAck     <= 1'b0;
            r_busErr   <= 1'b0;
            r_grant    <= GNT_NONE;
        end else begin
            r_iAck   <= 1'b0;
            r_dAck   <= 1'b0;
            r_busErr <= 1'b0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_anyReq) begin
                        r_owner    <= w_winner;
                        r_memAddr  <= (w_winner == OWN_D) ? bus.d_addr : bus.i_addr;
                        r_memWdata <= (w_winner == OWN_D) ? bus.d_wdata : '0;
                        r_memRead  <= !w_isStore;
                        r_memWrt   <= w_isStore;
                        r_grant    <= (w_winner == OWN_D) ? GNT_D : GNT_I;
                        r_state    <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (bus.mem_ready || w_tc) begin
                        if (r_owner == OWN_I) begin
                            r_iRdata <= w_capData;
                        end else if (!r_memWrt) begin
                            r_dRdata <= w_capData;
                        end
                        r_iAck    <= (r_owner == OWN_I);
                        r_dAck    <= (r_owner == OWN_D);
                        r_busErr  <= !bus.mem_ready;
                        r_memRead <= 1'b0;
                        r_memWrt  <= 1'b0;
                        r_grant   <= GNT_NONE;
                        r_state   <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    r_lastData <= (r_owner == OWN_D);
                    r_state    <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign bus.mem_addr  = r_memAddr;
    assign bus.mem_wdata = r_memWdata;
    assign bus.mem_read  = r_memRead;
    assign bus.mem_wrt   = r_memWrt;
    assign bus.i_rdata   = r_iRdata;
    assign bus.d_rdata   = r_dRdata;
    assign bus.i_ack     = r_iAck;
    assign bus.d_ack     = r_dAck;
    assign bus.bus_err   = r_busErr;
    assign bus.grant     = r_grant;

endmodule
